// File: rtl/alarm_btn_pkg.sv
// -----------------------------------------------------------------------------
// alarm_btn_pkg
// Shared types and default constants for the "set alarm" pushbutton debouncer.
//   alarm_btn_state_t      : debounce FSM states
//   ALARM_BTN_DEBOUNCE_DEF : default stable-cycle count (10 ms at 50 MHz)
//   ALARM_BTN_LONG_DEF     : default long-press hold count (2 s at 50 MHz)
// -----------------------------------------------------------------------------
package alarm_btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } alarm_btn_state_t;

  localparam int ALARM_BTN_DEBOUNCE_DEF = 500000;
  localparam int ALARM_BTN_LONG_DEF     = 100000000;

endpackage : alarm_btn_pkg

// File: rtl/alarm_btn_sync.sv
// -----------------------------------------------------------------------------
// alarm_btn_sync
// N-stage flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk_i   : destination clock
//   rst_ni  : asynchronous active-low reset; all stages load RST_VAL
//   d_i     : asynchronous input
//   q_o     : synchronized output (last stage)
// Parameters:
//   STAGES  : number of flops, at least 2
//   RST_VAL : value every stage takes during reset
// -----------------------------------------------------------------------------
module alarm_btn_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : alarm_btn_sync

// File: rtl/alarm_button_debounce.sv
// -----------------------------------------------------------------------------
// alarm_button_debounce
// Debounces the active-low "set alarm" pushbutton and presents a clean,
// registered level for the CPU PIO in_port, plus a one-cycle press strobe and
// an optional one-cycle long-press strobe.
// Ports:
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   btn_n       : raw pushbutton, low = pressed, asynchronous to clk
//   btn_level   : debounced state, 1 = pressed (registered, glitch-free)
//   press_pulse : one-cycle strobe on each accepted press
//   long_press  : one-cycle strobe once per press held LONG_CYCLES cycles
// Configuration macro:
//   ALARM_BTN_LONGPRESS_EN : when defined, builds the hold counter that drives
//                            long_press; otherwise long_press is tied to 0.
// -----------------------------------------------------------------------------
module alarm_button_debounce
  import alarm_btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = ALARM_BTN_DEBOUNCE_DEF,
  parameter int LONG_CYCLES     = ALARM_BTN_LONG_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic long_press
);

  localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the debounce/long-press arithmetic cannot honour.
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_cfg_check
    $error("alarm_button_debounce: illegal parameter combination");
  end

  logic btn_sync_n;
  logic s;

  // Reset to released so a held button at reset release is seen as a new press.
  alarm_btn_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (btn_n),
    .q_o    (btn_sync_n)
  );

  assign s = ~btn_sync_n;

  alarm_btn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // Counter is cleared on every state change, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign btn_level   = level_q;
  assign press_pulse = press_q;

`ifdef ALARM_BTN_LONGPRESS_EN
  localparam int                HOLD_W   = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 2);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // Restarts on each accepted press; counts through release bounces because
  // btn_level stays high in RELEASE_WAIT. Saturation makes the strobe one-shot.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if (level_q && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_W'(1);
      long_d = (hold_q == HOLD_PRE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule : alarm_button_debounce

// File: tb/tb_alarm_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_alarm_button_debounce
// Scoreboard bench: each driven cycle pushes the expected outputs computed by a
// run-length reference model; a monitor pops and compares after every edge.
// -----------------------------------------------------------------------------
module tb_alarm_button_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
`ifdef ALARM_BTN_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef struct packed {
    logic lvl;
    logic pr;
    logic lp;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic btn_n   = 1'b0;
  logic btn_level, press_pulse, long_press;

  always #5 clk = ~clk;

  alarm_button_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_n       (btn_n),
    .btn_level   (btn_level),
    .press_pulse (press_pulse),
    .long_press  (long_press)
  );

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  // Reference model: the FSM sees btn_n delayed by SYNC edges; the level flips
  // once the observed input has disagreed with it for DEB+1 consecutive edges.
  bit sync_m[$];
  bit lvl_m;
  int run_m;
  int age_m;
  bit armed_m;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got lvl/press/long=%b required %b at t=%0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    sync_m.delete();
    for (int i = 0; i < SYNC; i++) sync_m.push_back(1'b1);
    lvl_m   = 1'b0;
    run_m   = 0;
    age_m   = 0;
    armed_m = 1'b0;
  endtask

  task automatic step_now(input bit b);
    exp_t e;
    bit   obs, pressed, lvl_before;
    btn_n = b;
    obs = sync_m.pop_front();
    sync_m.push_back(b);
    pressed    = !obs;
    lvl_before = lvl_m;
    e.pr = 1'b0;
    e.lp = 1'b0;
    if (pressed != lvl_m) begin
      run_m++;
      if (run_m == DEB + 1) begin
        lvl_m = pressed;
        run_m = 0;
        e.pr  = pressed;
      end
    end else begin
      run_m = 0;
    end
    if (e.pr) begin
      age_m   = 0;
      armed_m = 1'b1;
    end else if (lvl_before && armed_m) begin
      age_m++;
      if (age_m == LONG - 1) begin
        e.lp    = LONG_EN;
        armed_m = 1'b0;
      end
    end
    e.lvl = lvl_m;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit b);
    @(negedge clk);
    step_now(b);
  endtask

  task automatic hold(input bit b, input int n);
    repeat (n) step(b);
  endtask

  // Asynchronous reset mid-cycle, immediate zero check, release with button b.
  task automatic async_reset(input string name, input bit b);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk(name, {btn_level, press_pulse, long_press}, 3'b000);
    btn_n = b;
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_held"}, {btn_level, press_pulse, long_press}, 3'b000);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    step_now(b);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("scoreboard", {btn_level, press_pulse, long_press}, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got still running required finished by t=200000");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int len;
    bit b;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {btn_level, press_pulse, long_press}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    step_now(1'b0);           // held through reset: new press, then long press
    hold(1'b0, 39);
    hold(1'b1, 15);
    hold(1'b0, 3);            // bounce rejection
    hold(1'b1, 2);
    hold(1'b0, 3);
    hold(1'b1, 12);
    hold(1'b0, 10);           // clean press then release bounce
    hold(1'b1, 2);
    hold(1'b0, 5);
    hold(1'b1, 12);
    hold(1'b0, 40);           // second long press re-arms
    hold(1'b1, 12);
    for (int i = 0; i < 30; i++) begin
      b   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 28)) : int'($urandom_range(1, 7));
      hold(b, len);
    end
    hold(1'b1, 12);
    hold(1'b0, 3);            // now in PRESS_WAIT
    async_reset("reset_press_wait", 1'b1);
    hold(1'b1, 12);
    hold(1'b0, 12);           // level high
    async_reset("reset_pressed", 1'b1);
    hold(1'b1, 12);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 3'(exp_q.size()), 3'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_alarm_button_debounce
